// File: rtl/tmr_vote_pkg.sv
// tmr_vote_pkg: shared types and constants for the TMR sensor voter
package tmr_vote_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, VOTE, OUT} state_e;
  localparam int NUM_CH = 3;
  localparam int MISS_W = 4;
endpackage

// File: rtl/vote3_core.sv
// vote3_core: combinational vote over three words with a present mask
//   data_i  channel i word at [i*DATA_W +: DATA_W]
//   mask_i  channels holding a sample
//   val_o   voted value, agree_o present channels equal to val_o, err_o vote untrusted
//   VOTE_MEDIAN_EN: full vote is the unsigned median instead of bitwise majority
module vote3_core
  import tmr_vote_pkg::*;
#(
  parameter int DATA_W     = 12,
  parameter bit SINGLE_ERR = 1'b1
) (
  input  logic [NUM_CH*DATA_W-1:0] data_i,
  input  logic [NUM_CH-1:0]        mask_i,
  output logic [DATA_W-1:0]        val_o,
  output logic [NUM_CH-1:0]        agree_o,
  output logic                     err_o
);
  logic [DATA_W-1:0] a, b, c, full, lo, hi, one;
  logic [1:0] p;
  assign a = data_i[0*DATA_W +: DATA_W];
  assign b = data_i[1*DATA_W +: DATA_W];
  assign c = data_i[2*DATA_W +: DATA_W];
`ifdef VOTE_MEDIAN_EN
  logic [DATA_W-1:0] mn_ab, mx_ab, mn_mx;
  assign mn_ab = a < b ? a : b;
  assign mx_ab = a < b ? b : a;
  assign mn_mx = mx_ab < c ? mx_ab : c;
  assign full  = mn_ab > mn_mx ? mn_ab : mn_mx;
`else
  assign full = (a & b) | (a & c) | (b & c);
`endif
  // With two present, lo is the lower-index sample and hi the other one.
  assign lo  = mask_i[0] ? a : b;
  assign hi  = mask_i[2] ? c : b;
  assign one = mask_i[0] ? a : mask_i[1] ? b : c;
  assign p   = 2'(mask_i[0]) + 2'(mask_i[1]) + 2'(mask_i[2]);
  always_comb begin
    val_o   = p == 2'd3 ? full : p == 2'd2 ? lo : p == 2'd1 ? one : '0;
    agree_o = {mask_i[2] && c == val_o, mask_i[1] && b == val_o, mask_i[0] && a == val_o};
    err_o   = p == 2'd3 ? ~|agree_o : p == 2'd2 ? lo != hi : p == 2'd1 ? SINGLE_ERR : 1'b1;
  end
endmodule

// File: rtl/tmr_sensor_voter.sv
// tmr_sensor_voter: sequential TMR voter with per-channel fault retirement
//   ch_valid/ch_data  per-channel sample strobes and samples
//   out_ready         consumer accepts result
//   fault_clr         clears ch_fault and miss counters
//   out_valid/out_data/out_agree/vote_err  held voted result
//   ch_fault          sticky per-channel fault flags
//   VOTE_MEDIAN_EN selects median voting for three present samples
module tmr_sensor_voter
  import tmr_vote_pkg::*;
#(
  parameter int DATA_W       = 12,
  parameter int TIMEOUT_CYC  = 255,
  parameter int FAULT_THRESH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic                     out_ready,
  input  logic                     fault_clr,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [NUM_CH-1:0]        out_agree,
  output logic                     vote_err,
  output logic [NUM_CH-1:0]        ch_fault
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  state_e state_q, state_d;
  logic [NUM_CH-1:0] got_q, got_d, fault_q, fault_d, agree_q, agree_d, acc, v_agree;
  logic [NUM_CH*DATA_W-1:0] smp_q, smp_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [MISS_W-1:0] miss_q [NUM_CH];
  logic [MISS_W-1:0] miss_d [NUM_CH];
  logic [DATA_W-1:0] data_q, data_d, v_val;
  logic err_q, err_d, v_err, covered, tmo, done;
  assign acc     = (state_q == IDLE || state_q == COLLECT) ? ch_valid & ~got_q & ~fault_q : '0;
  assign covered = &(got_q | fault_q);
  // Leaving on timer == TIMEOUT_CYC-1 keeps COLLECT to at most TIMEOUT_CYC cycles.
  assign tmo     = timer_q == TW'(TIMEOUT_CYC - 1);
  assign done    = state_q == OUT && out_ready;
  vote3_core #(.DATA_W(DATA_W), .SINGLE_ERR(FAULT_THRESH > 1)) u_core (
    .data_i (smp_q),
    .mask_i (got_q),
    .val_o  (v_val),
    .agree_o(v_agree),
    .err_o  (v_err)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = |acc ? COLLECT : IDLE;
      COLLECT: state_d = covered || tmo ? VOTE : COLLECT;
      VOTE:    state_d = OUT;
      default: state_d = out_ready ? IDLE : OUT;
    endcase
  end
  always_comb begin
    out_valid = state_q == OUT;
    out_data  = data_q;
    out_agree = agree_q;
    vote_err  = out_valid && err_q;
    ch_fault  = fault_q;
  end
  always_comb begin
    got_d   = done ? '0 : got_q | acc;
    smp_d   = smp_q;
    timer_d = state_q == IDLE ? '0 : state_q == COLLECT ? timer_q + 1'b1 : timer_q;
    data_d  = state_q == VOTE ? v_val : data_q;
    agree_d = state_q == VOTE ? v_agree : agree_q;
    err_d   = state_q == VOTE ? v_err : err_q;
    fault_d = fault_q;
    miss_d  = miss_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (acc[i]) smp_d[i*DATA_W +: DATA_W] = ch_data[i*DATA_W +: DATA_W];
      if (fault_clr) begin
        miss_d[i]  = '0;
        fault_d[i] = 1'b0;
      end else if (state_q == VOTE && !fault_q[i]) begin
        miss_d[i]  = v_agree[i] ? '0 : miss_q[i] == MISS_W'(FAULT_THRESH) ? miss_q[i] : miss_q[i] + 1'b1;
        fault_d[i] = miss_d[i] == MISS_W'(FAULT_THRESH);
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      got_q   <= '0;
      smp_q   <= '0;
      timer_q <= '0;
      data_q  <= '0;
      agree_q <= '0;
      err_q   <= 1'b0;
      fault_q <= '0;
      miss_q  <= '{default: '0};
    end else begin
      got_q   <= got_d;
      smp_q   <= smp_d;
      timer_q <= timer_d;
      data_q  <= data_d;
      agree_q <= agree_d;
      err_q   <= err_d;
      fault_q <= fault_d;
      miss_q  <= miss_d;
    end
  end
endmodule

// File: tb/tb_tmr_sensor_voter.sv
// tb_tmr_sensor_voter: scoreboard bench for tmr_sensor_voter
module tb_tmr_sensor_voter;
  localparam int W = 12;
  localparam int TO = 8;
  localparam int TH = 4;
  typedef struct packed {logic [W-1:0] d; logic [2:0] ag; logic e;} res_t;
  logic clk = 0, rst, out_ready, fault_clr, out_valid, vote_err;
  logic [2:0] ch_valid, out_agree, ch_fault;
  logic [3*W-1:0] ch_data;
  logic [W-1:0] out_data;
  logic [W-1:0] ms [3];
  logic [2:0] mgot, mfault;
  res_t q[$];
  int checks = 0, errors = 0;
  tmr_sensor_voter #(.DATA_W(W), .TIMEOUT_CYC(TO), .FAULT_THRESH(TH)) dut (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_data(ch_data), .out_ready(out_ready),
    .fault_clr(fault_clr), .out_valid(out_valid), .out_data(out_data), .out_agree(out_agree),
    .vote_err(vote_err), .ch_fault(ch_fault)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic res_t model(input logic [2:0] m, input logic [W-1:0] s0, s1, s2);
    res_t r;
    logic [W-1:0] v [3];
    logic [W-1:0] lst [3];
    logic [W-1:0] t;
    int p;
    r = '0;
    p = 0;
    v = '{s0, s1, s2};
    lst = '{default: '0};
    for (int i = 0; i < 3; i++) if (m[i]) begin lst[p] = v[i]; p++; end
    if (p == 3) begin
`ifdef VOTE_MEDIAN_EN
      for (int i = 0; i < 2; i++) for (int j = 0; j < 2 - i; j++)
        if (lst[j] > lst[j+1]) begin t = lst[j]; lst[j] = lst[j+1]; lst[j+1] = t; end
      r.d = lst[1];
`else
      for (int k = 0; k < W; k++) r.d[k] = (int'(s0[k]) + int'(s1[k]) + int'(s2[k])) >= 2;
`endif
    end else if (p > 0) r.d = lst[0];
    for (int i = 0; i < 3; i++) r.ag[i] = m[i] && v[i] == r.d;
    r.e = p == 0 ? 1'b1 : p == 1 ? (TH > 1) : p == 2 ? (lst[0] != lst[1]) : (r.ag == 3'b000);
    return r;
  endfunction
  task automatic feed(input logic [2:0] m, input logic [W-1:0] a, b, c, input bit last);
    logic [W-1:0] in3 [3];
    in3 = '{a, b, c};
    ch_valid = m;
    ch_data = {c, b, a};
    for (int i = 0; i < 3; i++) if (m[i] && !mgot[i] && !mfault[i]) begin ms[i] = in3[i]; mgot[i] = 1'b1; end
    @(posedge clk); #1;
    ch_valid = '0;
    if (last) begin q.push_back(model(mgot, ms[0], ms[1], ms[2])); mgot = '0; end
  endtask
  task automatic take(input string tag, input int lat);
    int k;
    res_t r;
    k = 0;
    do begin @(negedge clk); k++; end while (!out_valid && k < 200);
    check({tag, "_valid"}, out_valid, 1);
    if (lat > 0) check({tag, "_lat"}, k, lat);
    if (q.size() == 0) check({tag, "_sb_empty"}, 0, 1);
    else begin
      r = q.pop_front();
      check({tag, "_data"}, out_data, r.d);
      check({tag, "_agree"}, out_agree, r.ag);
      check({tag, "_err"}, vote_err, r.e);
    end
  endtask
  task automatic ack();
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    check("idle_after_ack", out_valid, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    rst = 1; ch_valid = 0; ch_data = 0; out_ready = 0; fault_clr = 0;
    mgot = 0; mfault = 0; ms = '{default: '0};
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_agree", out_agree, 0);
    check("rst_err", vote_err, 0);
    check("rst_fault", ch_fault, 0);
    @(posedge clk); #1;
    feed(3'b111, 12'h1A5, 12'h1A5, 12'h1A5, 1);
    take("same", 3);
    ack();
    feed(3'b111, 12'h0F0, 12'h0FF, 12'h00F, 1);
    take("split", 3);
    ack();
    feed(3'b001, 12'h123, 12'h000, 12'h000, 0);
    feed(3'b001, 12'h456, 12'h000, 12'h000, 0);
    feed(3'b110, 12'h000, 12'h123, 12'h123, 1);
    take("stagger", 3);
    ack();
    for (int r = 1; r <= 4; r++) begin
      feed(3'b011, W'(12'h200 + r), W'(12'h200 + r), 12'h000, 1);
      take("silent", TO + 2);
      check(r == 4 ? "fault_set" : "fault_pending", ch_fault, r == 4 ? 3'b100 : 3'b000);
      ack();
    end
    mfault = 3'b100;
    feed(3'b011, 12'h321, 12'h321, 12'h000, 1);
    take("two_ch", 3);
    ack();
    feed(3'b111, 12'h100, 12'h101, 12'hABC, 1);
    take("p2_diff", 3);
    for (int i = 0; i < 5; i++) begin
      ch_valid = 3'b111;
      ch_data = {W'($urandom), W'($urandom), W'($urandom)};
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, 12'h100);
      check("hold_meta", {out_agree, vote_err}, {3'b001, 1'b1});
    end
    ch_valid = 0;
    ack();
    fault_clr = 1;
    @(posedge clk); #1;
    fault_clr = 0;
    mfault = 0;
    check("clr_idle", ch_fault, 0);
    for (int r = 1; r <= 3; r++) begin
      feed(3'b011, 12'h050, 12'h050, 12'h000, 1);
      take("pre_clr", TO + 2);
      ack();
    end
    feed(3'b011, 12'h060, 12'h060, 12'h000, 1);
    repeat (TO) @(posedge clk);
    #1 fault_clr = 1;
    @(posedge clk); #1;
    fault_clr = 0;
    take("clr_race", 0);
    check("clr_race_fault", ch_fault, 0);
    ack();
    feed(3'b011, 12'h070, 12'h070, 12'h000, 1);
    take("post_clr", TO + 2);
    check("post_clr_fault", ch_fault, 0);
    ack();
    feed(3'b011, 12'h555, 12'h555, 12'h000, 0);
    mgot = 0;
    #2 rst = 1;
    #3 rst = 0;
    @(negedge clk);
    check("mid_rst_out", {out_valid, out_data, out_agree, vote_err}, 0);
    check("mid_rst_fault", ch_fault, 0);
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_quiet", out_valid, 0);
    end
    @(posedge clk); #1;
    feed(3'b100, 12'h000, 12'h000, 12'h777, 1);
    take("fresh", TO + 2);
    ack();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
